// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: valid/ready front end for a fixed-latency, non-stallable FPU.
// Requests are registered onto the FPU inputs. A shadow pipeline carries
// tag/err alongside each operation until its result is captured into an
// in-order first-word-fall-through response FIFO. Admission is credit based:
// in-flight plus buffered operations never exceed DEPTH, so the FIFO cannot
// overflow while the consumer stalls.
module fpu_op_sequencer #(
    parameter int LATENCY = 4,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_opcode,
    input  logic [31:0]      fpu_o,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [31:0]      QNAN     = 32'h7FC0_0000;

    // Reserved opcodes return a quiet NaN instead of whatever the FPU produced.
    function automatic logic [31:0] result_sel(input logic err, input logic [31:0] o);
        return err ? QNAN : o;
    endfunction

    // FIFO pointers wrap modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [31:0]      fpu_a_q, fpu_a_d;
    logic [31:0]      fpu_b_q, fpu_b_d;
    logic [1:0]       fpu_op_q, fpu_op_d;

    logic [LATENCY-1:0] shd_vld_q, shd_vld_d;
    logic [LATENCY-1:0] shd_err_q, shd_err_d;
    logic [TAG_W-1:0]   shd_tag_q [LATENCY];
    logic [TAG_W-1:0]   shd_tag_d [LATENCY];

    logic [31:0]      mem_data_q [DEPTH];
    logic [31:0]      mem_data_d [DEPTH];
    logic [TAG_W-1:0] mem_tag_q  [DEPTH];
    logic [TAG_W-1:0] mem_tag_d  [DEPTH];
    logic [DEPTH-1:0] mem_err_q, mem_err_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;

    logic accept;
    logic pop;
    logic push;

    // Handshakes: ready depends only on registered credit state and rst_n.
    always_comb begin
        req_ready = rst_n && (outst_q < DEPTH_C);
        rsp_valid = (count_q != '0);
        accept    = req_valid && req_ready;
        pop       = rsp_valid && rsp_ready;
        push      = shd_vld_q[LATENCY-1];
    end

    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_opcode = fpu_op_q;
    assign rsp_data   = mem_data_q[rd_ptr_q];
    assign rsp_tag    = mem_tag_q[rd_ptr_q];
    assign rsp_err    = mem_err_q[rd_ptr_q];
    assign busy       = (outst_q != '0);

    // Operand registers hold their last value unless a request is accepted.
    always_comb begin
        fpu_a_d  = fpu_a_q;
        fpu_b_d  = fpu_b_q;
        fpu_op_d = fpu_op_q;
        if (accept) begin
            fpu_a_d  = req_a;
            fpu_b_d  = req_b;
            fpu_op_d = req_op;
        end
    end

    // Shadow pipeline shifts unconditionally, mirroring the non-stallable FPU.
    always_comb begin
        shd_vld_d    = '0;
        shd_err_d    = '0;
        shd_vld_d[0] = accept;
        shd_err_d[0] = req_op[1] ^ req_op[0];
        shd_tag_d[0] = req_tag;
        for (int i = 1; i < LATENCY; i++) begin
            shd_vld_d[i] = shd_vld_q[i-1];
            shd_err_d[i] = shd_err_q[i-1];
            shd_tag_d[i] = shd_tag_q[i-1];
        end
    end

    // Response FIFO: capture from the last shadow stage, pop at the head.
    always_comb begin
        mem_data_d = mem_data_q;
        mem_tag_d  = mem_tag_q;
        mem_err_d  = mem_err_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            mem_data_d[wr_ptr_q] = result_sel(shd_err_q[LATENCY-1], fpu_o);
            mem_tag_d[wr_ptr_q]  = shd_tag_q[LATENCY-1];
            mem_err_d[wr_ptr_q]  = shd_err_q[LATENCY-1];
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Outstanding credit counter: in-flight plus buffered operations.
    always_comb begin
        case ({accept, pop})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Control and visible-output state, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpu_a_q   <= '0;
            fpu_b_q   <= '0;
            fpu_op_q  <= '0;
            shd_vld_q <= '0;
            mem_err_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            outst_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_tag_q[i]  <= '0;
            end
        end else begin
            fpu_a_q    <= fpu_a_d;
            fpu_b_q    <= fpu_b_d;
            fpu_op_q   <= fpu_op_d;
            shd_vld_q  <= shd_vld_d;
            mem_data_q <= mem_data_d;
            mem_tag_q  <= mem_tag_d;
            mem_err_q  <= mem_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
        end
    end

    // Shadow tag/err are only meaningful under their valid bit, so no reset.
    always_ff @(posedge clk) begin
        shd_err_q <= shd_err_d;
        shd_tag_q <= shd_tag_d;
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Bench for fpu_op_sequencer: FPU stand-in, queue-based response model,
// per-cycle compare process, directed scenarios and a randomized phase.
module tb_fpu_op_sequencer;

    localparam int LATENCY = 4;
    localparam int TAG_W   = 4;
    localparam int DEPTH   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [1:0]       fpu_opcode;
    logic [31:0]      fpu_o;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    always #5 clk = ~clk;

    fpu_op_sequencer #(.LATENCY(LATENCY), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy)
    );

    // FPU stand-in: exact for the pinned test vectors, a deterministic scramble otherwise.
    function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 2'b11 && a == 32'h03E2D22D && b == 32'h3CE374D4) return 32'h014987E1;
        return (a ^ {b[15:0], b[31:16]}) + {30'd0, op} + 32'h1234_0000;
    endfunction

    // Fixed-latency FPU: inputs driven at edge t, result sampled at edge t+LATENCY.
    logic [31:0] fpu_pipe [LATENCY-1];
    initial for (int i = 0; i < LATENCY-1; i++) fpu_pipe[i] = 32'h0;
    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_ref(fpu_a, fpu_b, fpu_opcode);
        for (int i = 1; i < LATENCY-1; i++) fpu_pipe[i] <= fpu_pipe[i-1];
    end
    assign fpu_o = fpu_pipe[LATENCY-2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: every accepted op becomes visible LATENCY edges later,
    // leaves in acceptance order, and the queue length is the outstanding count.
    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic [31:0]      rdy;
    } exp_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rec_t;

    exp_t        q[$];
    rec_t        log_q[$];
    int          cyc  = 0;
    logic [31:0] m_a  = 32'h0;
    logic [31:0] m_b  = 32'h0;
    logic [1:0]  m_op = 2'b00;

    function automatic bit head_visible();
        return (q.size() != 0) && (int'(q[0].rdy) <= cyc);
    endfunction

    // Advance the model on each rising edge using the bench-driven inputs.
    always @(posedge clk) begin : model
        bit   vis;
        bit   rdy;
        bit   e;
        exp_t ent;
        vis = head_visible();
        rdy = (q.size() < DEPTH);
        if (!rst_n) begin
            q.delete();
            m_a  = 32'h0;
            m_b  = 32'h0;
            m_op = 2'b00;
        end else begin
            if (vis && rsp_ready) void'(q.pop_front());
            if (req_valid && rdy) begin
                e        = (req_op == 2'b01) || (req_op == 2'b10);
                ent.data = e ? 32'h7FC00000 : fpu_ref(req_a, req_b, req_op);
                ent.tag  = req_tag;
                ent.err  = e;
                ent.rdy  = 32'(cyc + 1 + LATENCY);
                q.push_back(ent);
                m_a  = req_a;
                m_b  = req_b;
                m_op = req_op;
            end
        end
        cyc++;
    end

    // Compare DUT outputs against the model every cycle, away from the edge.
    always @(negedge clk) begin : compare
        bit vis;
        vis = head_visible();
        chk("req_ready", {31'd0, req_ready}, {31'd0, rst_n && (q.size() < DEPTH)});
        chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, vis});
        chk("fpu_a", fpu_a, m_a);
        chk("fpu_b", fpu_b, m_b);
        chk("fpu_opcode", {30'd0, fpu_opcode}, {30'd0, m_op});
        if (vis) begin
            chk("rsp_data", rsp_data, q[0].data);
            chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, q[0].tag});
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, q[0].err});
        end
        if (rst_n && rsp_valid && rsp_ready) log_q.push_back({rsp_data, rsp_tag, rsp_err});
    end

    // Offer one request and hold it until accepted; starts and ends just after a rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag);
        bit acc;
        int n;
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
    endtask

    // Count falling edges until a response is visible; returns at a falling edge.
    task automatic wait_rsp(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 50);
        chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        rsp_ready = 1'b1;
        while (busy && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin : stim
        int k;
        bit acc;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'h0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'h0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'h0);
        chk("rst_fpu_a", fpu_a, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single multiply
        rsp_ready = 1'b1;
        send(32'h03E2D22D, 32'h3CE374D4, 2'b11, 4'd5);
        chk("mul_fpu_a", fpu_a, 32'h03E2D22D);
        chk("mul_fpu_op", {30'd0, fpu_opcode}, 32'd3);
        wait_rsp(k);
        chk("mul_latency", 32'(k), 32'd5);
        chk("mul_data", rsp_data, 32'h014987E1);
        chk("mul_tag", {28'd0, rsp_tag}, 32'd5);
        chk("mul_err", {31'd0, rsp_err}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mul_busy_after_pop", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Single add
        send(32'h3F800000, 32'h40000000, 2'b00, 4'd1);
        chk("add_fpu_a", fpu_a, 32'h3F800000);
        chk("add_fpu_b", fpu_b, 32'h40000000);
        chk("add_fpu_op", {30'd0, fpu_opcode}, 32'd0);
        wait_rsp(k);
        chk("add_data", rsp_data, 32'h40400000);
        chk("add_tag", {28'd0, rsp_tag}, 32'd1);
        @(posedge clk); #1;
        wait_idle();

        // Backpressure: four credits, then stall until the consumer drains
        log_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 2'b00, TAG_W'(i));
        @(negedge clk);
        chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
        req_a = $urandom; req_b = $urandom; req_op = 2'b11; req_tag = 4'd4; req_valid = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_still_blocked", {31'd0, req_ready}, 32'd0);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        chk("bp_none_popped", 32'(log_q.size()), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(req_a, req_b, 2'b11, 4'd4);
        send($urandom, $urandom, 2'b00, 4'd5);
        wait_idle();
        chk("bp_count", 32'(log_q.size()), 32'd6);
        for (int i = 0; i < log_q.size(); i++) chk("bp_order", {28'd0, log_q[i].tag}, 32'(i));

        // Reserved opcode between two adds
        log_q.delete();
        send(32'h3F800000, 32'h40000000, 2'b00, 4'd2);
        send(32'h11111111, 32'h22222222, 2'b01, 4'd7);
        send(32'h3F800000, 32'h40000000, 2'b00, 4'd3);
        wait_idle();
        chk("rsv_count", 32'(log_q.size()), 32'd3);
        if (log_q.size() == 3) begin
            chk("rsv_first_tag", {28'd0, log_q[0].tag}, 32'd2);
            chk("rsv_first_err", {31'd0, log_q[0].err}, 32'd0);
            chk("rsv_mid_data", log_q[1].data, 32'h7FC00000);
            chk("rsv_mid_tag", {28'd0, log_q[1].tag}, 32'd7);
            chk("rsv_mid_err", {31'd0, log_q[1].err}, 32'd1);
            chk("rsv_last_tag", {28'd0, log_q[2].tag}, 32'd3);
        end

        // Full FIFO, then continuous traffic with simultaneous push and pop
        log_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 2'b00, TAG_W'(i));
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        chk("full_ready_low", {31'd0, req_ready}, 32'd0);
        chk("full_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 4; i < 16; i++) send($urandom, $urandom, 2'b11, TAG_W'(i));
        wait_idle();
        chk("full_count", 32'(log_q.size()), 32'd16);
        for (int i = 0; i < log_q.size(); i++) chk("full_order", {28'd0, log_q[i].tag}, 32'(i));

        // Reset with three operations in flight
        log_q.delete();
        send($urandom, $urandom, 2'b00, 4'd8);
        send($urandom, $urandom, 2'b11, 4'd9);
        send($urandom, $urandom, 2'b00, 4'd10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("rstmid_dropped", 32'(log_q.size()), 32'd0);
        send(32'h3F800000, 32'h40000000, 2'b00, 4'd11);
        wait_rsp(k);
        chk("rstmid_next_latency", 32'(k), 32'd5);
        chk("rstmid_next_data", rsp_data, 32'h40400000);
        chk("rstmid_next_tag", {28'd0, rsp_tag}, 32'd11);
        @(posedge clk); #1;
        wait_idle();

        // Randomized traffic, reserved opcodes included, random consumer stalls
        req_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc || !req_valid) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_a     = $urandom;
                req_b     = $urandom;
                req_op    = 2'($urandom_range(0, 3));
                req_tag   = TAG_W'($urandom);
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
        end
        req_valid = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
